// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
// Forms the XLEN-wide immediate for the selected format, flags encodings
// that are illegal for this XLEN, and queues {imm, tag, illegal} in a
// 2-entry FIFO with valid/ready handshakes on both sides.

package imm_gen_pkg;
    typedef enum logic [3:0] {
        ENUM_IMM_NONE = 4'd0,
        ENUM_IMM_I    = 4'd1,
        ENUM_IMM_S    = 4'd2,
        ENUM_IMM_B    = 4'd3,
        ENUM_IMM_U    = 4'd4,
        ENUM_IMM_J    = 4'd5,
        ENUM_IMM_SH   = 4'd6,
        ENUM_IMM_Z    = 4'd7
    } imm_type_e;
endpackage

module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,   // 32 or 64
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  imm_type_e        in_immType,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Sign-extend a value already laid out as a 32-bit two's complement
    // number to XLEN; the signed size cast replicates bit 31.
    function automatic logic [XLEN-1:0] sext_to_xlen(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // Zero-extend a small unsigned field (shamt / zimm) to XLEN.
    function automatic logic [XLEN-1:0] zext_to_xlen(input logic [5:0] v);
        return XLEN'(v);
    endfunction

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^in_inst[6:0];

    logic [XLEN-1:0] imm_p0;
    logic            ill_p0;
    logic            vld_p0;
    logic            pop;

    logic [1:0]       state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             ill_q [2];

    // ---- stage p0: combinational immediate formation on the input ----

    // Build the immediate and the illegal flag from the raw instruction.
    always_comb begin
        imm_p0 = '0;
        ill_p0 = 1'b0;
        case (in_immType)
            ENUM_IMM_NONE: begin
                imm_p0 = '0;
            end
            ENUM_IMM_I: imm_p0 = sext_to_xlen({{20{in_inst[31]}}, in_inst[31:20]});
            ENUM_IMM_S: imm_p0 = sext_to_xlen({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
            ENUM_IMM_B: imm_p0 = sext_to_xlen({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                               in_inst[30:25], in_inst[11:8], 1'b0});
            ENUM_IMM_J: imm_p0 = sext_to_xlen({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                               in_inst[20], in_inst[30:21], 1'b0});
            ENUM_IMM_U: imm_p0 = sext_to_xlen({in_inst[31:12], 12'b0});
            ENUM_IMM_SH: begin
                if (XLEN == 64) begin
                    imm_p0 = zext_to_xlen(in_inst[25:20]);
                end else begin
                    // shamt[5] is not encodable on RV32: report it, keep the low 5 bits.
                    imm_p0 = zext_to_xlen({1'b0, in_inst[24:20]});
                    ill_p0 = in_inst[25];
                end
            end
            ENUM_IMM_Z: imm_p0 = zext_to_xlen({1'b0, in_inst[19:15]});
            default: begin
                imm_p0 = '0;
                ill_p0 = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign vld_p0    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy and pointer next-state from push/pop.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (vld_p0) wr_ptr_d = ~wr_ptr_q;
        if (pop)    rd_ptr_d = ~rd_ptr_q;
        case (state_q)
            ST_EMPTY: if (vld_p0) state_d = ST_ONE;
            ST_ONE: begin
                if (vld_p0 && !pop)      state_d = ST_FULL;
                else if (pop && !vld_p0) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // ---- stage p1: 2-entry output buffer ----

    // Control state; reset empties the buffer and drops a coincident push.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; a push never targets the head slot while it is occupied.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            imm_q[wr_ptr_q] <= imm_p0;
            tag_q[wr_ptr_q] <= in_tag;
            ill_q[wr_ptr_q] <= ill_p0;
        end
    end

    // Outputs are forced to zero when nothing is presented, so stale or
    // never-written storage is never visible.
    assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_tag     = out_valid ? tag_q[rd_ptr_q] : '0;
    assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: directed table, backpressure / push-pop /
// reset sequences and random traffic against a queue-based reference model.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_tag, out_imm, out_tag;
    imm_type_e   in_immType;

    logic        v64, r64, ov64, ordy64, oill64;
    logic [31:0] inst64, tag64, otag64;
    logic [63:0] oimm64;
    imm_type_e   typ64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_immType(in_immType), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(v64), .in_ready(r64), .in_inst(inst64),
        .in_immType(typ64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(ordy64), .out_imm(oimm64),
        .out_tag(otag64), .out_illegal(oill64)
    );

    int    checks = 0;
    int    errors = 0;
    string ph = "init";

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        ill;
    } ent_t;
    ent_t q[$];

    logic        ov_en;
    logic [63:0] ov_imm;
    logic        ov_ill;

    typedef struct {
        imm_type_e   typ;
        logic [31:0] inst;
        logic [31:0] imm;
        logic        ill;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s actual=%h required=%h", ph, nm, act, exp);
        end
    endtask

    // Reference immediate computed with integer arithmetic on the fields.
    task automatic ref_imm(input imm_type_e t, input logic [31:0] x, input int xlen,
                           output logic [63:0] imm, output logic ill);
        longint v;
        v   = 0;
        ill = 1'b0;
        case (t)
            ENUM_IMM_NONE: v = 0;
            ENUM_IMM_I: begin
                v = x[31:20];
                if (v >= 2048) v = v - 4096;
            end
            ENUM_IMM_S: begin
                v = x[31:25] * 32 + x[11:7];
                if (v >= 2048) v = v - 4096;
            end
            ENUM_IMM_B: begin
                v = x[31] * 4096 + x[7] * 2048 + x[30:25] * 32 + x[11:8] * 2;
                if (v >= 4096) v = v - 8192;
            end
            ENUM_IMM_J: begin
                v = x[31] * (1 << 20) + x[19:12] * 4096 + x[20] * 2048 + x[30:21] * 2;
                if (v >= (1 << 20)) v = v - (1 << 21);
            end
            ENUM_IMM_U: begin
                v = x[31:12] * 4096;
                if (v >= 64'd2147483648) v = v - 64'd4294967296;
            end
            ENUM_IMM_SH: begin
                if (xlen == 64) v = x[25:20];
                else begin
                    v   = x[24:20];
                    ill = x[25];
                end
            end
            ENUM_IMM_Z: v = x[19:15];
            default: begin
                v   = 0;
                ill = 1'b1;
            end
        endcase
        imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    endtask

    // One clock of the 32-bit DUT: check outputs at negedge, update model at posedge.
    task automatic step();
        logic        do_push, do_pop, rl;
        logic [63:0] ri;
        ent_t        e;
        @(negedge clk);
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_imm", out_imm, q[0].imm[31:0]);
            chk("out_tag", out_tag, q[0].tag);
            chk("out_illegal", out_illegal, q[0].ill);
        end else begin
            chk("idle_imm", out_imm, 0);
            chk("idle_tag", out_tag, 0);
            chk("idle_ill", out_illegal, 0);
        end
        do_push = in_valid && (q.size() < 2);
        do_pop  = out_ready && (q.size() > 0);
        if (ov_en) begin
            ri = ov_imm;
            rl = ov_ill;
        end else begin
            ref_imm(in_immType, in_inst, 32, ri, rl);
        end
        e.imm = ri;
        e.tag = in_tag;
        e.ill = rl;
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        #1;
    endtask

    // Single push into the 64-bit DUT, checked on the following cycle.
    task automatic t64(input imm_type_e t, input logic [31:0] x, input logic [63:0] e,
                       input logic ei, input string nm);
        logic [31:0] tg;
        tg     = $urandom;
        typ64  = t;
        inst64 = x;
        tag64  = tg;
        v64    = 1'b1;
        @(posedge clk);
        #1 v64 = 1'b0;
        @(negedge clk);
        chk({nm, "_vld"}, ov64, 1);
        chk({nm, "_imm"}, oimm64, e);
        chk({nm, "_ill"}, oill64, ei);
        chk({nm, "_tag"}, otag64, tg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] e64;
        logic        i64;
        logic [31:0] x;
        imm_type_e   t;

        tbl[0] = '{ENUM_IMM_I,    32'hFF80_0000, 32'hFFFF_FFF8, 1'b0};
        tbl[1] = '{ENUM_IMM_S,    32'h0000_0A00, 32'h0000_0014, 1'b0};
        tbl[2] = '{ENUM_IMM_B,    32'hFE00_0E80, 32'hFFFF_FFFC, 1'b0};
        tbl[3] = '{ENUM_IMM_J,    32'h0010_0000, 32'h0000_0800, 1'b0};
        tbl[4] = '{ENUM_IMM_U,    32'h1234_5000, 32'h1234_5000, 1'b0};
        tbl[5] = '{ENUM_IMM_Z,    32'h000F_8000, 32'h0000_001F, 1'b0};
        tbl[6] = '{ENUM_IMM_SH,   32'h0230_0000, 32'h0000_0003, 1'b1};
        tbl[7] = '{imm_type_e'(4'd9), 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[8] = '{ENUM_IMM_NONE, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_immType = ENUM_IMM_NONE;
        in_tag = '0; out_ready = 1'b1; ov_en = 1'b0; ov_imm = '0; ov_ill = 1'b0;
        v64 = 1'b0; inst64 = '0; typ64 = ENUM_IMM_NONE; tag64 = '0; ordy64 = 1'b1;

        @(posedge clk);
        #1;
        ph = "reset";
        step();
        step();
        rst = 1'b0;
        step();

        ph = "table";
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_inst = tbl[i].inst; in_immType = tbl[i].typ;
            in_tag = 32'h100 + i;
            ov_en = 1'b1; ov_imm = {32'b0, tbl[i].imm}; ov_ill = tbl[i].ill;
            step();
        end
        in_valid = 1'b0; ov_en = 1'b0;
        step();
        step();

        ph = "backpressure";
        out_ready = 1'b0; in_valid = 1'b1; in_immType = ENUM_IMM_I; in_inst = 32'h0010_0000;
        in_tag = 1; step();
        in_tag = 2; step();
        chk("full_in_ready", in_ready, 0);
        in_tag = 3;
        repeat (4) step();
        chk("stall_tag", out_tag, 1);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();

        ph = "pushpop";
        in_valid = 1'b1; out_ready = 1'b0; in_tag = 32'h200;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_tag = 32'h201 + i;
            step();
            chk("pp_in_ready", in_ready, 1);
            chk("pp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        step();
        step();

        ph = "midreset";
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = 32'h300; step();
        in_tag = 32'h301; step();
        rst = 1'b1; in_tag = 32'h3EE; step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) step();

        ph = "random";
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_inst    = $urandom;
            in_immType = imm_type_e'(4'($urandom_range(0, 15)));
            in_tag     = $urandom;
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        ph = "xlen64";
        t64(ENUM_IMM_U,  32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, "u_neg");
        t64(ENUM_IMM_SH, 32'h03F0_0000, 64'h0000_0000_0000_003F, 1'b0, "sh63");
        t64(ENUM_IMM_I,  32'hFF80_0000, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, "i_neg8");
        t64(ENUM_IMM_J,  32'h8000_0000, 64'hFFFF_FFFF_FFF0_0000, 1'b0, "j_min");
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            t = imm_type_e'(4'($urandom_range(0, 15)));
            ref_imm(t, x, 64, e64, i64);
            t64(t, x, e64, i64, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, flow-controlled immediate generator for the decode stage.
- Successor to the combinational immediate generator:
  - XLEN is parametrised (32 or 64).
  - Adds a shift-amount format and a CSR zimm format.
  - Flags illegal encodings.
- A 2-entry output buffer decouples decode from the issue stage through valid/ready handshakes.
- Sits between fetch/decode and the register-read/issue stage.

Parameters:
- XLEN, 32, datapath width of out_imm; legal values are 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each instruction (PC or ROB id).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept this cycle.
- in_inst  input  32  raw instruction word.
- in_immType  input  imm_type_e  format select: ENUM_IMM_NONE/I/S/B/U/J, plus ENUM_IMM_SH and ENUM_IMM_Z (both added to imm_type_e in the types package).
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  out_imm/out_tag/out_illegal hold a valid entry.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the presented entry.
- out_illegal  output  1  encoding illegal for this XLEN/format.

Behaviour:
- Transfers:
  - Push = in_valid && in_ready.
  - Pop = out_valid && out_ready.
- Immediate formation (combinational on the input, captured on push). Sign extension goes to XLEN from the stated sign bit.
  - I: inst[31:20], sign bit inst[31].
  - S: {inst[31:25], inst[11:7]}, sign bit inst[31].
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, sign bit inst[31].
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, sign bit inst[31].
  - U: {inst[31:12], 12'b0}. When XLEN=64, bits 63:32 replicate inst[31].
  - SH: zero-extended inst[24:20] when XLEN=32; inst[25:20] when XLEN=64. When XLEN=32 and inst[25]=1: illegal=1 and the immediate is still inst[24:20].
  - Z: zero-extended inst[19:15].
  - NONE: 0, illegal=0.
  - Any other enum value: 0, illegal=1.
- Buffer: 2 entries (imm, tag, illegal), FIFO order. Occupancy state machine:
  - EMPTY:
    - push -> ONE.
  - ONE:
    - push only -> FULL.
    - pop only -> EMPTY.
    - push and pop -> ONE.
  - FULL:
    - pop -> ONE.
    - push cannot occur.
- Handshake rules:
  - in_ready = (state != FULL). It depends only on registered state; there is no combinational path from out_ready to in_ready.
  - out_valid = (state != EMPTY).
  - Latency: an entry pushed at edge N is presented from cycle N+1.
  - Throughput: 1 per cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, out_imm/out_tag/out_illegal are stable, and the head entry is not overwritten by a push.
  - Push and pop in the same cycle in ONE: the head advances to the new entry and occupancy stays 1.
  - in_valid asserted while in_ready=0: ignored, nothing captured. Upstream holds its data.
- Reset (synchronous), on any cycle including mid-stream:
  - State -> EMPTY; all stored entries discarded.
  - out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - A push coinciding with rst is dropped.
- No X propagation: out_imm is 0 whenever out_valid=0.

Test Plan:
- XLEN=32, out_ready=1, one push per cycle:
  - I -8 -> FFFFFFF8.
  - S +20 -> 00000014.
  - B -4 -> FFFFFFFC.
  - J +2048 -> 00000800.
  - U 0x12345000 -> 12345000.
  - Z with rs1 field=0x1F -> 0000001F.
  - Each appears exactly 1 cycle after its push, in order.
- XLEN=64: U with inst[31:12]=0x80000 -> FFFFFFFF80000000. SH with inst[25:20]=0x3F -> 000000000000003F, illegal=0.
- XLEN=32: SH with inst[25]=1 and inst[24:20]=3 -> out_imm=3, out_illegal=1. Undefined enum -> out_imm=0, out_illegal=1.
- Backpressure, with out_ready=0:
  - Push tags 1, 2, 3.
  - Required: tags 1 and 2 accepted; in_ready=0 after the second push; tag 3 is held off.
  - out_tag stays 1 while stalled.
  - Raise out_ready: tags appear in order 1, 2, 3 with no loss or duplication.
- Simultaneous push/pop in ONE, repeated for 8 cycles -> occupancy stays 1, in_ready=1 throughout, and outputs stream tags in order.
- Reset asserted for 1 cycle while FULL with in_valid=1 -> next cycle out_valid=0, out_imm=0, in_ready=1. The entry offered during reset never appears.
